// File: rtl/mips_regfile_mp_if.sv
// Bus bundle for the multi-read-port MIPS register file: read ports, byte-enabled
// write port, jal link port and the write/link conflict flag.
interface mips_regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                       rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [DATA_W/8-1:0]        wr_be;
  logic                       link_en;
  logic [DATA_W-1:0]          link_pc;
  logic                       wr_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, link_en, link_pc,
    input  rd_data, wr_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be, link_en, link_pc,
    output rd_data, wr_conflict
  );
endinterface

// File: rtl/mips_regfile_mp.sv
// MIPS_32 general-purpose register file: N registered write-first read ports,
// one byte-enabled write port and a jal link port that overrides it.
module mips_regfile_mp #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned LINK_REG    = 31,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  mips_regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic                     r_wr_conflict;

  logic [DATA_W-1:0]        w_next [DEPTH];
  logic [DATA_W-1:0]        w_link_val;
  logic                     w_conflict;

  // Post-write image of every register: byte merge, then link override, then zero pin.
  always_comb begin
    w_link_val = bus.link_pc + DATA_W'(4);
    w_conflict = bus.link_en && bus.wr_en && (bus.wr_addr == ADDR_W'(LINK_REG));
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = r_mem[i];
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) w_next[i][8*b +: 8] = bus.wr_data[8*b +: 8];
        end
      end
      if (bus.link_en && (i == LINK_REG)) w_next[i] = w_link_val;
      if ((ZERO_REG_EN != 0) && (i == 0)) w_next[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data     <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_next[i];
      // Reads sample the post-write image so a same-cycle write is visible.
      if (bus.rd_en) begin
        for (int p = 0; p < NUM_RD; p++) begin
          r_rd_data[p*DATA_W +: DATA_W] <= w_next[bus.rd_addr[p*ADDR_W +: ADDR_W]];
        end
      end
      r_wr_conflict <= w_conflict;
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp: array-based reference model checked every cycle,
// plus directed vectors with literal expected values.
module tb_mips_regfile_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mips_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  mips_regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .LINK_REG(31), .ZERO_REG_EN(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register array updated from the architectural rules.
  logic [31:0] m_regs [32];
  logic [31:0] m_rd   [NR];
  logic        m_conf;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nr [32];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      for (int p = 0; p < NR; p++) m_rd[p] = 32'd0;
      m_conf  = 1'b0;
      m_valid = 1'b1;
    end else begin
      nr = m_regs;
      if (bus.wr_en) begin
        for (int b = 0; b < 4; b++)
          if (bus.wr_be[b]) nr[bus.wr_addr][8*b +: 8] = bus.wr_data[8*b +: 8];
      end
      if (bus.link_en) nr[31] = bus.link_pc + 32'd4;
      nr[0]  = 32'd0;
      m_conf = bus.link_en && bus.wr_en && (bus.wr_addr == 5'd31);
      if (bus.rd_en)
        for (int p = 0; p < NR; p++) m_rd[p] = nr[bus.rd_addr[p*AW +: AW]];
      m_regs = nr;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int p = 0; p < NR; p++) begin
        n_tests++;
        if (bus.rd_data[p*DW +: DW] !== m_rd[p]) begin
          n_fail++;
          $display("FAIL model_rd%0d t=%0t got=%h exp=%h", p, $time, bus.rd_data[p*DW +: DW], m_rd[p]);
        end
      end
      n_tests++;
      if (bus.wr_conflict !== m_conf) begin
        n_fail++;
        $display("FAIL model_conflict t=%0t got=%b exp=%b", $time, bus.wr_conflict, m_conf);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = 4'b0000;
    bus.link_en = 1'b0;
    bus.link_pc = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    bus.rd_en = 1'b1; bus.rd_addr = {a1, a0};
  endtask

  function automatic logic [31:0] port(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b1;
    idle();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rd(5'd7, 5'd3);
    @(negedge clk);
    check("reset_rd0", port(0), 32'h0);
    check("reset_rd1", port(1), 32'h0);
    check("reset_conflict", 32'(bus.wr_conflict), 32'h0);
    idle(); wr(5'd8, 32'hDEADBEEF, 4'b1111); rd(5'd8, 5'd8);
    @(negedge clk);
    check("bypass_p0", port(0), 32'hDEADBEEF);
    check("bypass_p1_same_reg", port(1), 32'hDEADBEEF);
    idle(); wr(5'd8, 32'h00000055, 4'b0001); rd(5'd0, 5'd8);
    @(negedge clk);
    check("lb_merge", port(0), 32'hDEADBE55);
    check("read_zero_port1", port(1), 32'h0);
    idle(); wr(5'd8, 32'h00001234, 4'b0011); rd(5'd0, 5'd8);
    @(negedge clk);
    check("lh_merge", port(0), 32'hDEAD1234);
    idle(); wr(5'd8, 32'hFFFFFFFF, 4'b0000); rd(5'd0, 5'd8);
    @(negedge clk);
    check("be_zero_no_change", port(0), 32'hDEAD1234);
    idle(); wr(5'd31, 32'h11111111, 4'b1111);
    bus.link_en = 1'b1; bus.link_pc = 32'h00400010; rd(5'd8, 5'd31);
    @(negedge clk);
    check("link_wins", port(0), 32'h00400014);
    check("conflict_set", 32'(bus.wr_conflict), 32'h1);
    idle();
    @(negedge clk);
    check("conflict_one_cycle", 32'(bus.wr_conflict), 32'h0);
    check("rd_hold_idle", port(0), 32'h00400014);
    bus.link_en = 1'b1; bus.link_pc = 32'hFFFFFFFC; wr(5'd0, 32'hFFFFFFFF, 4'b1111); rd(5'd0, 5'd31);
    @(negedge clk);
    check("link_wrap", port(0), 32'h0);
    check("zero_ignores_write", port(1), 32'h0);
    check("zero_write_no_conflict", 32'(bus.wr_conflict), 32'h0);
    idle(); wr(5'd5, 32'hA5A5A5A5, 4'b1111); rd(5'd5, 5'd5);
    @(negedge clk);
    check("reg5_written", port(0), 32'hA5A5A5A5);
    idle(); rst_n = 1'b0; wr(5'd5, 32'h5A5A5A5A, 4'b1111); rd(5'd5, 5'd5);
    @(negedge clk);
    check("reset_priority_rd", port(0), 32'h0);
    idle(); rst_n = 1'b1; rd(5'd8, 5'd5);
    @(negedge clk);
    check("reg5_cleared", port(0), 32'h0);
    check("reg8_cleared", port(1), 32'h0);
    idle(); wr(5'd5, 32'h12345678, 4'b1111); rd(5'd5, 5'd5);
    @(negedge clk);
    check("reg5_rewrite", port(0), 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      idle(); wr(5'd5, 32'(k) + 32'hC0DE0000, 4'b1111);
      @(negedge clk);
      check("rd_en0_hold", port(0), 32'h12345678);
    end
    idle(); rd(5'd5, 5'd5);
    @(negedge clk);
    check("last_hold_write_visible", port(0), 32'hC0DE0002);
    // Sweep: fill registers and read back in pairs, checked by the model.
    for (int i = 1; i < 32; i++) begin
      idle(); wr(5'(i), 32'h01010101 * 32'(i), 4'b1111); rd(5'(i - 1), 5'(i));
      @(negedge clk);
    end
    for (int i = 0; i < 32; i += 2) begin
      idle(); rd(5'(i + 1), 5'(i));
      @(negedge clk);
    end
    check("sweep_reg30", port(0), 32'h1E1E1E1E);
    check("sweep_reg31", port(1), 32'h1F1F1F1F);
    idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
